// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared state encodings and default widths for the CPU clock-enable sequencer.
// Optional feature macro: BREAKPOINT_EN (see cpu_clock_ctrl.sv).
package cpu_clock_ctrl_pkg;

   localparam int DEF_DIV_W = 24;
   localparam int DEF_CNT_W = 32;

   typedef enum logic [2:0] {
      ST_HALT     = 3'd0,
      ST_RUN      = 3'd1,
      ST_STEP_CYC = 3'd2,
      ST_STEP_INS = 3'd3,
      ST_BRK      = 3'd4
   } state_t;

   // States in which the rate divider runs and ce strobes come from its ticks.
   function automatic logic is_ticking(input state_t s);
      return (s == ST_RUN) || (s == ST_STEP_INS);
   endfunction

endpackage

// File: rtl/cpu_clock_ctrl_ce_divider.sv
// Rate divider: tick once every limit+1 enabled cycles; limit reloads from div_val
// on every tick and continuously while disabled.
module ce_divider #(
   parameter int DIV_W = 24
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             enable,
   input  logic [DIV_W-1:0] div_val,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] limit_q;

   assign tick = enable && (cnt_q == limit_q);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         limit_q <= '0;
      end else if (!enable || tick) begin
         cnt_q   <= '0;
         limit_q <= div_val;
      end else begin
         cnt_q   <= cnt_q + DIV_W'(1);
      end
   end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Run/halt/step sequencer producing the 6502 core clock enable.
// Define BREAKPOINT_EN to build the SYNC-qualified address breakpoint and BRK state.
module cpu_clock_ctrl
   import cpu_clock_ctrl_pkg::*;
#(
   parameter int DIV_W     = DEF_DIV_W,
   parameter int CNT_W     = DEF_CNT_W,
   parameter bit RESET_RUN = 1'b0
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             run_tgl,
   input  logic             step_cyc,
   input  logic             step_ins,
   input  logic [DIV_W-1:0] div_val,
   input  logic             cpu_sync,
   input  logic [15:0]      cpu_addr,
   input  logic [15:0]      bp_addr,
   input  logic             bp_arm,
   output logic             cpu_ce,
   output logic             running,
   output logic             bp_hit,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycle_count
);

   localparam state_t RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;

   state_t state_q;
   state_t next_state;
   logic   ce_next;
   logic   tick;
   logic   first_ce_q;
   logic   first_ce_d;
   logic   bp_match;

   ce_divider #(.DIV_W(DIV_W)) u_div (
      .clk_in  (clk_in),
      .rst     (rst),
      .enable  (is_ticking(state_q)),
      .div_val (div_val),
      .tick    (tick)
   );

`ifdef BREAKPOINT_EN
   // Set on leaving BRK so the instruction that tripped the breakpoint can execute.
   logic bp_skip_q;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         bp_skip_q <= 1'b0;
      end else if (ce_next) begin
         bp_skip_q <= 1'b0;
      end else if (state_q == ST_BRK && next_state != ST_BRK) begin
         bp_skip_q <= 1'b1;
      end
   end

   assign bp_match = bp_arm && cpu_sync && (cpu_addr == bp_addr) && !bp_skip_q;
`else
   logic bp_unused;
   assign bp_unused = ^{bp_addr, bp_arm, cpu_addr};
   assign bp_match  = 1'b0;
`endif

   always_comb begin
      next_state = state_q;
      ce_next    = 1'b0;
      case (state_q)
         ST_HALT, ST_BRK: begin
            if (run_tgl) begin
               next_state = ST_RUN;
            end else if (step_ins) begin
               next_state = ST_STEP_INS;
            end else if (step_cyc) begin
               next_state = ST_STEP_CYC;
               ce_next    = 1'b1;
            end
         end
         ST_STEP_CYC: begin
            next_state = ST_HALT;
         end
         ST_RUN: begin
            if (run_tgl) begin
               next_state = ST_HALT;
            end else if (tick) begin
               if (bp_match) begin
                  next_state = ST_BRK;
               end else begin
                  ce_next = 1'b1;
               end
            end
         end
         ST_STEP_INS: begin
            // A SYNC tick after the first ce is the next opcode fetch: stop in front of it.
            if (run_tgl) begin
               next_state = ST_HALT;
            end else if (tick) begin
               if (!first_ce_q) begin
                  ce_next = 1'b1;
               end else if (bp_match) begin
                  next_state = ST_BRK;
               end else if (cpu_sync) begin
                  next_state = ST_HALT;
               end else begin
                  ce_next = 1'b1;
               end
            end
         end
         default: begin
            next_state = ST_HALT;
         end
      endcase
   end

   assign first_ce_d = (state_q == ST_STEP_INS) && (next_state == ST_STEP_INS) &&
                       (first_ce_q || ce_next);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q     <= RESET_STATE;
         cpu_ce      <= 1'b0;
         running     <= RESET_RUN;
         bp_hit      <= 1'b0;
         first_ce_q  <= 1'b0;
         cycle_count <= '0;
      end else begin
         state_q    <= next_state;
         cpu_ce     <= ce_next;
         running    <= is_ticking(next_state);
         bp_hit     <= (next_state == ST_BRK);
         first_ce_q <= first_ce_d;
         if (ce_next) begin
            cycle_count <= cycle_count + CNT_W'(1);
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed self-checking bench for cpu_clock_ctrl; breakpoint checks follow BREAKPOINT_EN.
module tb_cpu_clock_ctrl;

   localparam int DIV_W = 24;
   localparam int CNT_W = 32;

   logic             clk_in = 1'b0;
   logic             rst;
   logic             run_tgl;
   logic             step_cyc;
   logic             step_ins;
   logic [DIV_W-1:0] div_val;
   logic             cpu_sync;
   logic [15:0]      cpu_addr;
   logic [15:0]      bp_addr;
   logic             bp_arm;
   logic             cpu_ce;
   logic             running;
   logic             bp_hit;
   logic [2:0]       state;
   logic [CNT_W-1:0] cycle_count;

   int vectors     = 0;
   int miscompares = 0;

   always #10 clk_in = ~clk_in;

   cpu_clock_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .RESET_RUN(1'b0)) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .run_tgl     (run_tgl),
      .step_cyc    (step_cyc),
      .step_ins    (step_ins),
      .div_val     (div_val),
      .cpu_sync    (cpu_sync),
      .cpu_addr    (cpu_addr),
      .bp_addr     (bp_addr),
      .bp_arm      (bp_arm),
      .cpu_ce      (cpu_ce),
      .running     (running),
      .bp_hit      (bp_hit),
      .state       (state),
      .cycle_count (cycle_count)
   );

   task automatic count_ce(input int n, output int ces);
      ces = 0;
      repeat (n) begin
         @(negedge clk_in);
         if (cpu_ce === 1'b1) ces++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; run_tgl = 1'b0; step_cyc = 1'b0; step_ins = 1'b0;
      div_val = '0; cpu_sync = 1'b0; cpu_addr = '0; bp_addr = '0; bp_arm = 1'b0;
      repeat (3) @(negedge clk_in);
      rst = 1'b0;
      @(negedge clk_in);
      vectors++;
      if (state !== 3'd0 || cpu_ce !== 1'b0 || running !== 1'b0 || bp_hit !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: state=%0d ce=%b running=%b bp_hit=%b, required 0/0/0/0",
                  state, cpu_ce, running, bp_hit);
      end
      vectors++;
      if (cycle_count !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_count: got %0d required 0", cycle_count);
      end
   endtask

   task automatic test_step_cyc();
      int ces;
      step_cyc = 1'b1;
      @(negedge clk_in);
      step_cyc = 1'b0;
      vectors++;
      if (cpu_ce !== 1'b1 || state !== 3'd2) begin
         miscompares++;
         $display("[TB] FAIL step_cyc_ce: ce=%b state=%0d, required ce=1 state=2", cpu_ce, state);
      end
      count_ce(10, ces);
      vectors++;
      if (ces != 0 || state !== 3'd0 || cycle_count !== 32'd1) begin
         miscompares++;
         $display("[TB] FAIL step_cyc_after: extra_ce=%0d state=%0d count=%0d, required 0/0/1",
                  ces, state, cycle_count);
      end
   endtask

   task automatic test_run_rate();
      logic exp_ce;
      int   ces;
      div_val = 24'd3;
      run_tgl = 1'b1;
      @(negedge clk_in);
      run_tgl = 1'b0;
      vectors++;
      if (state !== 3'd1 || running !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL run_enter: state=%0d running=%b, required 1/1", state, running);
      end
      for (int k = 1; k <= 16; k++) begin
         exp_ce = (k >= 5) && (k % 4 == 1);
         vectors++;
         if (cpu_ce !== exp_ce) begin
            miscompares++;
            $display("[TB] FAIL run_rate_cycle%0d: ce=%b required %b", k, cpu_ce, exp_ce);
         end
         if (k < 16) @(negedge clk_in);
      end
      vectors++;
      if (cycle_count !== 32'd4) begin
         miscompares++;
         $display("[TB] FAIL run_rate_count: got %0d required 4", cycle_count);
      end
      // Halt lands on the same cycle as a divider tick, which must be dropped.
      run_tgl = 1'b1;
      @(negedge clk_in);
      run_tgl = 1'b0;
      vectors++;
      if (cpu_ce !== 1'b0 || state !== 3'd0 || running !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL run_halt: ce=%b state=%0d running=%b, required 0/0/0",
                  cpu_ce, state, running);
      end
      count_ce(12, ces);
      vectors++;
      if (ces != 0 || cycle_count !== 32'd4) begin
         miscompares++;
         $display("[TB] FAIL run_halted_quiet: ce=%0d count=%0d, required 0/4", ces, cycle_count);
      end
   endtask

   task automatic test_div_zero();
      logic exp_ce;
      div_val = '0;
      run_tgl = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_in);
         exp_ce = (k >= 2) && (k <= 5);
         vectors++;
         if (cpu_ce !== exp_ce) begin
            miscompares++;
            $display("[TB] FAIL div0_cycle%0d: ce=%b required %b", k, cpu_ce, exp_ce);
         end
         run_tgl = (k == 5);
      end
      vectors++;
      if (state !== 3'd0 || cycle_count !== 32'd8) begin
         miscompares++;
         $display("[TB] FAIL div0_end: state=%0d count=%0d, required 0/8", state, cycle_count);
      end
   endtask

   task automatic test_step_ins();
      logic       exp_ce;
      logic [2:0] exp_st;
      div_val  = 24'd3;
      cpu_sync = 1'b0;
      step_ins = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk_in);
         step_ins = 1'b0;
         exp_ce = (k == 5) || (k == 9) || (k == 13);
         exp_st = (k <= 16) ? 3'd3 : 3'd0;
         vectors++;
         if (cpu_ce !== exp_ce) begin
            miscompares++;
            $display("[TB] FAIL step_ins_ce%0d: ce=%b required %b", k, cpu_ce, exp_ce);
         end
         vectors++;
         if (state !== exp_st) begin
            miscompares++;
            $display("[TB] FAIL step_ins_state%0d: state=%0d required %0d", k, state, exp_st);
         end
         if (k == 13) cpu_sync = 1'b1;
      end
      cpu_sync = 1'b0;
      vectors++;
      if (cycle_count !== 32'd11 || running !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL step_ins_end: count=%0d running=%b, required 11/0", cycle_count, running);
      end
   endtask

   task automatic test_coincident();
      int ces;
      div_val  = 24'd3;
      run_tgl  = 1'b1;
      step_cyc = 1'b1;
      @(negedge clk_in);
      step_cyc = 1'b0;
      vectors++;
      if (cpu_ce !== 1'b0 || state !== 3'd1 || running !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL coincident: ce=%b state=%0d running=%b, required 0/1/1",
                  cpu_ce, state, running);
      end
      @(negedge clk_in);
      run_tgl = 1'b0;
      count_ce(6, ces);
      vectors++;
      if (ces != 0 || state !== 3'd0 || cycle_count !== 32'd11) begin
         miscompares++;
         $display("[TB] FAIL coincident_end: ce=%0d state=%0d count=%0d, required 0/0/11",
                  ces, state, cycle_count);
      end
   endtask

   task automatic test_discarded();
      div_val = 24'd20;
      run_tgl = 1'b1;
      @(negedge clk_in);
      run_tgl  = 1'b0;
      step_cyc = 1'b1;
      @(negedge clk_in);
      step_cyc = 1'b0;
      step_ins = 1'b1;
      for (int k = 2; k <= 8; k++) begin
         vectors++;
         if (cpu_ce !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL discard_ce%0d: ce=%b required 0", k, cpu_ce);
         end
         @(negedge clk_in);
         step_ins = 1'b0;
      end
      vectors++;
      if (state !== 3'd1) begin
         miscompares++;
         $display("[TB] FAIL discard_state: state=%0d required 1", state);
      end
      run_tgl = 1'b1;
      @(negedge clk_in);
      run_tgl = 1'b0;
      vectors++;
      if (state !== 3'd0 || cycle_count !== 32'd11) begin
         miscompares++;
         $display("[TB] FAIL discard_end: state=%0d count=%0d, required 0/11", state, cycle_count);
      end
   endtask

   task automatic test_breakpoint();
      div_val  = '0;
      bp_addr  = 16'hC000;
      cpu_addr = 16'hC000;
      cpu_sync = 1'b1;
      bp_arm   = 1'b1;
      run_tgl  = 1'b1;
      @(negedge clk_in);
      run_tgl = 1'b0;
      @(negedge clk_in);
`ifdef BREAKPOINT_EN
      begin
         int ces;
         vectors++;
         if (state !== 3'd4 || bp_hit !== 1'b1 || cpu_ce !== 1'b0 || running !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_stop: state=%0d bp_hit=%b ce=%b running=%b, required 4/1/0/0",
                     state, bp_hit, cpu_ce, running);
         end
         count_ce(4, ces);
         vectors++;
         if (ces != 0 || state !== 3'd4) begin
            miscompares++;
            $display("[TB] FAIL bp_hold: ce=%0d state=%0d, required 0/4", ces, state);
         end
         run_tgl = 1'b1;
         @(negedge clk_in);
         run_tgl = 1'b0;
         vectors++;
         if (state !== 3'd1 || bp_hit !== 1'b0 || cpu_ce !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_resume: state=%0d bp_hit=%b ce=%b, required 1/0/0",
                     state, bp_hit, cpu_ce);
         end
         @(negedge clk_in);
         vectors++;
         if (cpu_ce !== 1'b1 || state !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL bp_skip_ce: ce=%b state=%0d, required 1/1", cpu_ce, state);
         end
         @(negedge clk_in);
         vectors++;
         if (cpu_ce !== 1'b0 || state !== 3'd4 || bp_hit !== 1'b1 || cycle_count !== 32'd12) begin
            miscompares++;
            $display("[TB] FAIL bp_rehit: ce=%b state=%0d bp_hit=%b count=%0d, required 0/4/1/12",
                     cpu_ce, state, bp_hit, cycle_count);
         end
      end
`else
      vectors++;
      if (state !== 3'd1 || bp_hit !== 1'b0 || cpu_ce !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL nobp_run: state=%0d bp_hit=%b ce=%b, required 1/0/1",
                  state, bp_hit, cpu_ce);
      end
`endif
      bp_arm = 1'b0; cpu_sync = 1'b0; cpu_addr = '0;
      rst = 1'b1;
      @(negedge clk_in);
      rst = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_reset_mid_step();
      int ces;
      step_cyc = 1'b1;
      @(negedge clk_in);
      step_cyc = 1'b0;
      @(negedge clk_in);
      div_val  = 24'd3;
      step_ins = 1'b1;
      @(negedge clk_in);
      step_ins = 1'b0;
      vectors++;
      if (state !== 3'd3 || cycle_count !== 32'd1) begin
         miscompares++;
         $display("[TB] FAIL mid_step_enter: state=%0d count=%0d, required 3/1", state, cycle_count);
      end
      @(negedge clk_in);
      rst = 1'b1;
      #1;
      vectors++;
      if (state !== 3'd0 || cpu_ce !== 1'b0 || running !== 1'b0 || cycle_count !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL mid_step_reset: state=%0d ce=%b running=%b count=%0d, required 0/0/0/0",
                  state, cpu_ce, running, cycle_count);
      end
      @(negedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;
      count_ce(10, ces);
      vectors++;
      if (ces != 0 || state !== 3'd0) begin
         miscompares++;
         $display("[TB] FAIL mid_step_quiet: ce=%0d state=%0d, required 0/0", ces, state);
      end
   endtask

   initial begin
      $display("[TB] starting cpu_clock_ctrl bench");
      test_reset();
      test_step_cyc();
      test_run_rate();
      test_div_zero();
      test_step_ins();
      test_coincident();
      test_discarded();
      test_breakpoint();
      test_reset_mid_step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
